// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the clock divider controller.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int CNT_WIDTH_DEF           = 16;
    localparam int DEFAULT_HALF_PERIOD_DEF = 25;

endpackage

// File: rtl/clock_divider_ctrl_if.sv
// Run/config handshake and divided-clock outputs of the clock divider controller.
interface clock_divider_ctrl_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 en;
    logic                 cfg_valid;
    logic [CNT_WIDTH-1:0] cfg_half_period;
    logic                 cfg_ready;
    logic                 clk_out;
    logic                 tick;
    logic                 update_done;
    logic [CNT_WIDTH-1:0] active_half_period;
    logic                 busy;

    modport master (
        output en, cfg_valid, cfg_half_period,
        input  cfg_ready, clk_out, tick, update_done, active_half_period, busy
    );

    modport slave (
        input  en, cfg_valid, cfg_half_period,
        output cfg_ready, clk_out, tick, update_done, active_half_period, busy
    );
endinterface

// File: rtl/half_period_counter.sv
// Half-period timer: counts while enabled, wraps to 0 on terminal count (limit-1).
module half_period_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 enable_i,
    input  logic [CNT_WIDTH-1:0] limit_i,
    output logic                 tc_o
);
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // clear wins over terminal count so a stop request never produces a toggle
    assign tc_o = enable_i && !clear_i && (cnt_q == (limit_i - ONE));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)       cnt_d = '0;
        else if (tc_o)     cnt_d = '0;
        else if (enable_i) cnt_d = cnt_q + ONE;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/clock_divider_ctrl.sv
// Glitch-free programmable clock divider: run/drain FSM plus half-period config
// handshake that only takes effect at a falling edge of clk_out (or at once when idle).
module clock_divider_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_WIDTH           = CNT_WIDTH_DEF,
    parameter int DEFAULT_HALF_PERIOD = DEFAULT_HALF_PERIOD_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    clock_divider_ctrl_if.slave  bus
);
    localparam logic [CNT_WIDTH-1:0] DEF_HP = CNT_WIDTH'(DEFAULT_HALF_PERIOD);

    state_e               state_q;
    logic                 clk_out_q, tick_q, upd_q, pend_q;
    logic [CNT_WIDTH-1:0] active_q, pend_val_q, cfg_val_d;
    logic                 running, stop_now, tc, fall, accept, apply;

    assign running  = (state_q != IDLE);
    // en low during the low phase stops immediately; the high phase is always finished
    assign stop_now = (state_q == RUN) && !bus.en && !clk_out_q;
    assign fall     = tc && clk_out_q;
    assign accept   = bus.cfg_valid && !pend_q;
    assign apply    = pend_q && (running ? fall : 1'b1);
    assign cfg_val_d = (bus.cfg_half_period == '0) ? CNT_WIDTH'(1) : bus.cfg_half_period;

    half_period_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .clear_i  (!running || stop_now),
        .enable_i (running),
        .limit_i  (active_q),
        .tc_o     (tc)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            upd_q      <= 1'b0;
            pend_q     <= 1'b0;
            pend_val_q <= DEF_HP;
            active_q   <= DEF_HP;
        end else begin
            tick_q <= tc && !clk_out_q;
            upd_q  <= apply;
            if (tc) clk_out_q <= !clk_out_q;

            case (state_q)
                IDLE:    if (bus.en) state_q <= RUN;
                RUN:     if (!bus.en) state_q <= (!clk_out_q || fall) ? IDLE : DRAIN;
                DRAIN:   if (fall) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            // apply and accept are mutually exclusive: accept needs pend_q low
            if (apply) begin
                active_q <= pend_val_q;
                pend_q   <= 1'b0;
            end else if (accept) begin
                pend_val_q <= cfg_val_d;
                pend_q     <= 1'b1;
            end
        end
    end

    assign bus.cfg_ready          = !pend_q;
    assign bus.clk_out            = clk_out_q;
    assign bus.tick               = tick_q;
    assign bus.update_done        = upd_q;
    assign bus.active_half_period = active_q;
    assign bus.busy               = running;
endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Bench: directed scenarios plus random en/config traffic against a phase-countdown model.
module tb_clock_divider_ctrl;
    localparam int CW  = 16;
    localparam int DEF = 3;

    logic clk_in = 1'b0;
    logic rst_n;
    always #5 clk_in = ~clk_in;

    clock_divider_ctrl_if #(.CNT_WIDTH(CW)) bus ();

    clock_divider_ctrl #(.CNT_WIDTH(CW), .DEFAULT_HALF_PERIOD(DEF)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // stimulus held between edges
    logic          rst_r = 1'b0;
    logic          en_r  = 1'b0;
    logic          cv_r  = 1'b0;
    logic [CW-1:0] cd_r  = '0;

    // model: mode 0 idle, 1 running, 2 finishing high phase; left = edges to next toggle
    int m_mode = 0, m_left = 0, m_h = DEF, m_pval = 0;
    bit m_clk = 0, m_tick = 0, m_upd = 0, m_pend = 0, m_acc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit acc;
        acc    = cv_r && !m_pend;
        m_tick = 0;
        m_upd  = 0;
        m_acc  = 0;
        if (!rst_r) begin
            m_mode = 0; m_clk = 0; m_left = 0; m_h = DEF; m_pend = 0;
            return;
        end
        if (m_mode == 0) begin
            if (m_pend) begin m_h = m_pval; m_pend = 0; m_upd = 1; end
            if (en_r) begin m_mode = 1; m_left = m_h; end
        end else if (m_mode == 1 && !en_r && !m_clk) begin
            m_mode = 0;
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_clk = !m_clk;
                if (m_clk) m_tick = 1;
                else begin
                    if (m_pend) begin m_h = m_pval; m_pend = 0; m_upd = 1; end
                    if (m_mode == 2 || !en_r) m_mode = 0;
                end
                m_left = m_h;
            end else if (m_mode == 1 && !en_r) begin
                m_mode = 2;
            end
        end
        if (acc) begin
            m_pend = 1;
            m_pval = (cd_r == 0) ? 1 : int'(cd_r);
            m_acc  = 1;
        end
    endtask

    task automatic step();
        rst_n               = rst_r;
        bus.en              = en_r;
        bus.cfg_valid       = cv_r;
        bus.cfg_half_period = cd_r;
        @(posedge clk_in);
        model_step();
        #1;
        chk("clk_out",   32'(bus.clk_out),            32'(m_clk));
        chk("tick",      32'(bus.tick),               32'(m_tick));
        chk("upd_done",  32'(bus.update_done),        32'(m_upd));
        chk("active_hp", 32'(bus.active_half_period), 32'(m_h));
        chk("cfg_ready", 32'(bus.cfg_ready),          32'(!m_pend));
        chk("busy",      32'(bus.busy),               32'(m_mode != 0));
        @(negedge clk_in);
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return bus.clk_out;
            1:       return bus.update_done;
            default: return bus.tick;
        endcase
    endfunction

    // steps until signal 'which' equals val; n = edges taken
    task automatic wait_for(input string tag, input int which, input logic val,
                            input int bound, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (sig(which) !== val && n < bound);
        if (sig(which) !== val) chk({tag, "_timeout"}, 32'(sig(which)), 32'(val));
    endtask

    initial begin
        int n, ticks;

        // reset and defaults
        rst_r = 0;
        step(); step();
        chk("rst_clk_out", 32'(bus.clk_out), 0);
        chk("rst_active",  bus.active_half_period, DEF);
        chk("rst_ready",   32'(bus.cfg_ready), 1);
        rst_r = 1;

        // H=3: first rise 3 edges after RUN entry, 6-cycle period, 50% duty
        en_r = 1;
        step();
        chk("run_busy", 32'(bus.busy), 1);
        wait_for("first_rise", 0, 1'b1, 20, n);
        chk("first_rise_edges", n, 3);
        wait_for("high_len", 0, 1'b0, 20, n);
        chk("high_len", n, 3);
        wait_for("low_len", 0, 1'b1, 20, n);
        chk("low_len", n, 3);
        chk("tick_on_rise", 32'(bus.tick), 1);

        // config 5 accepted mid-high-phase
        step();
        cv_r = 1; cd_r = 16'd5;
        step();
        cv_r = 0;
        chk("pend_ready", 32'(bus.cfg_ready), 0);
        wait_for("upd5", 1, 1'b1, 20, n);
        chk("upd5_at_fall", 32'(bus.clk_out), 0);
        chk("upd5_active", bus.active_half_period, 5);
        wait_for("low5", 0, 1'b1, 20, n);
        chk("low5_len", n, 5);

        // switch to H=4, then drop en one cycle into a high phase
        cv_r = 1; cd_r = 16'd4;
        wait_for("upd4", 1, 1'b1, 40, n);
        cv_r = 0;
        wait_for("rise4", 0, 1'b1, 20, n);
        step();
        en_r = 0;
        wait_for("drain", 0, 1'b0, 20, n);
        chk("drain_high_left", n, 3);
        chk("drain_busy", 32'(bus.busy), 0);
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            ticks += int'(bus.tick);
        end
        chk("drain_no_ticks", ticks, 0);

        // zero offered while idle becomes 1 on the next edge
        cv_r = 1; cd_r = 16'd0;
        step();
        cv_r = 0;
        step();
        chk("zero_upd", 32'(bus.update_done), 1);
        chk("zero_active", bus.active_half_period, 1);
        en_r = 1;
        wait_for("h1_rise", 2, 1'b1, 20, n);
        wait_for("h1_period", 2, 1'b1, 20, n);
        chk("h1_period", n, 2);

        // config accepted on the same edge as a falling toggle
        cv_r = 1; cd_r = 16'd3;
        wait_for("upd3", 1, 1'b1, 20, n);
        cv_r = 0;
        wait_for("rise3", 0, 1'b1, 20, n);
        step(); step();
        cv_r = 1; cd_r = 16'd2;
        step();
        cv_r = 0;
        chk("same_edge_fall", 32'(bus.clk_out), 0);
        chk("same_edge_noupd", 32'(bus.update_done), 0);
        chk("same_edge_old", bus.active_half_period, 3);
        wait_for("upd2", 1, 1'b1, 20, n);
        chk("upd2_delay", n, 6);
        chk("upd2_active", bus.active_half_period, 2);

        // reset mid-high-phase with a pending config
        wait_for("rise2", 0, 1'b1, 20, n);
        cv_r = 1; cd_r = 16'd6;
        step();
        cv_r = 0;
        rst_r = 0;
        step();
        chk("mid_rst_clk", 32'(bus.clk_out), 0);
        chk("mid_rst_ready", 32'(bus.cfg_ready), 1);
        chk("mid_rst_active", bus.active_half_period, DEF);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        rst_r = 1;

        // random traffic; offered values are held until accepted
        for (int i = 0; i < 3000; i++) begin
            rst_r = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 29) == 0) en_r = !en_r;
            if (cv_r && m_acc) cv_r = 0;
            if (!cv_r && $urandom_range(0, 5) == 0) begin
                cv_r = 1;
                cd_r = CW'($urandom_range(0, 6));
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/clock_divider_ctrl.md
CLOCK_DIVIDER_CTRL -- requirements
Module: clock_divider_ctrl

Interface
REQ-001 Parameter CNT_WIDTH, default 16, SHALL set the width of the half-period counter and of all half-period values.
REQ-002 Parameter DEFAULT_HALF_PERIOD, default 25, SHALL set the half-period in clk_in cycles that is loaded at reset. It SHALL lie in 1..2^CNT_WIDTH-1.
REQ-003 clk_in  input  1: the single clock. All logic SHALL be rising-edge triggered on it.
REQ-004 rst_n  input  1: reset, synchronous and active-low.
REQ-005 en  input  1: run request. High means generate clk_out; low means stop glitch-free.
REQ-006 cfg_valid  input  1: a new half-period is offered.
REQ-007 cfg_half_period  input  CNT_WIDTH: the offered half-period in clk_in cycles.
REQ-008 cfg_ready  output  1: the block can accept a configuration.
REQ-009 clk_out  output  1: the divided clock, registered.
REQ-010 tick  output  1: a one-cycle pulse coincident with each 0->1 transition of clk_out.
REQ-011 update_done  output  1: a one-cycle pulse in the cycle a pending configuration becomes active.
REQ-012 active_half_period  output  CNT_WIDTH: the half-period currently in use.
REQ-013 busy  output  1: high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have three states:
- IDLE: clk_out held at 0, timer held at 0.
- RUN: dividing.
- DRAIN: finishing the current high phase before stopping.
REQ-015 IDLE SHALL go to RUN on the edge where en is sampled high. The timer SHALL be 0 on RUN entry.
REQ-016 In RUN and DRAIN, the timer SHALL increment each cycle. When timer == active_half_period-1, the block SHALL toggle clk_out and clear the timer on the same edge.
REQ-017 While active_half_period is constant, both phases of clk_out SHALL last exactly active_half_period cycles. With half-period H, the first rise SHALL occur H edges after RUN entry.
REQ-018 tick SHALL be high for exactly the cycles in which the registered clk_out has just gone 0->1.
REQ-019 In RUN, when en is sampled low:
- if clk_out==0, the block SHALL go to IDLE on that edge (timer cleared);
- otherwise it SHALL go to DRAIN.
REQ-020 DRAIN SHALL go to IDLE on the falling toggle of clk_out. en rising during DRAIN SHALL be ignored until IDLE is reached. No clk_out phase shorter than active_half_period SHALL ever occur.
REQ-021 cfg_ready SHALL be the inverse of an internal pending flag. A transfer SHALL occur when cfg_valid && cfg_ready; it SHALL store the value in a pending register and set the flag.
REQ-022 An offered value of 0 SHALL be stored as 1.
REQ-023 A pending value SHALL be applied as follows, clearing the flag and pulsing update_done on that edge:
- in RUN or DRAIN, only on an edge where clk_out falls 1->0 (period boundary);
- in IDLE, on the edge following acceptance.
REQ-024 A value accepted on the same edge as a period boundary SHALL NOT be applied at that boundary; it SHALL be applied at the next boundary.
REQ-025 No new value SHALL be accepted while one is pending. cfg_valid held during this time SHALL wait, with no data loss.
REQ-026 Timer arithmetic SHALL be CNT_WIDTH unsigned with no overflow. The comparison SHALL use active_half_period-1.

Reset
REQ-027 When rst_n is sampled low, the block SHALL set:
- state=IDLE, timer=0, clk_out=0, tick=0, update_done=0;
- pending flag=0 (so cfg_ready=1), busy=0;
- active_half_period=DEFAULT_HALF_PERIOD.
REQ-028 Reset asserted mid-period SHALL take priority over all other events. Any pending configuration SHALL be discarded.

Structure
REQ-029 The state enumeration and the DEFAULT_HALF_PERIOD default SHALL reside in the shared package clk_div_pkg.
REQ-030 The timer and compare logic SHALL be one sub-module, half_period_counter, with inputs clear, enable and limit and output terminal-count. The FSM and configuration logic SHALL stay in clock_divider_ctrl.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Reset with DEFAULT=3, en=1 -> first clk_out rise 3 edges after RUN entry, then period 6 cycles, 50% duty, one tick per rise.
- Running with H=3, cfg_half_period=5 accepted mid-high-phase -> cfg_ready=0 until the next falling toggle; update_done pulses there; subsequent phases are 5 cycles.
- en dropped in the high phase with H=4 and 1 cycle elapsed -> clk_out stays high 3 more cycles, falls, busy=0, no further ticks.
- cfg_valid with value 0 while IDLE -> active_half_period=1 on the next edge, update_done pulses; en=1 then gives a clk_out period of 2 cycles.
- Config accepted on the same edge as a falling toggle -> old period kept for one more full period, then the new one applies.
- rst_n low for one cycle mid-high-phase with a config pending -> all outputs at reset values, cfg_ready=1, active_half_period=DEFAULT.
